// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the core-side memory responder.
// Holds the FSM state encoding and the I/O page/timeout defaults.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_IO_REQ,
        ST_DONE
    } state_t;

    localparam logic [7:0] IO_PAGE_DEF    = 8'hFF;
    localparam int         IO_TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_responder_if.sv
// Core bus between the CPU and the memory responder.
// The core holds request, address and data until m_wait is sampled low.
interface mem_responder_if #(
    parameter int ADR_TOP = 15
);

    logic             m_req;
    logic             m_wr;
    logic [ADR_TOP:0] m_addr;
    logic [7:0]       m_outdata;
    logic             m_wait;
    logic [7:0]       m_indata;

    modport master (
        output m_req,
        output m_wr,
        output m_addr,
        output m_outdata,
        input  m_wait,
        input  m_indata
    );

    modport slave (
        input  m_req,
        input  m_wr,
        input  m_addr,
        input  m_outdata,
        output m_wait,
        output m_indata
    );

endinterface

// File: rtl/bus_timer.sv
// 8-bit loadable down-counter with zero flag.
// Load has priority over decrement; the count stops at zero.
module bus_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && !zero) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/mem_responder.sv
// Core bus responder: wait-stated synchronous RAM plus an
// acknowledged I/O page with timeout and sticky bus error.
module mem_responder
    import mem_bus_pkg::*;
#(
    parameter int         ADR_TOP     = 15,
    parameter int         WAIT_CYCLES = 1,
    parameter logic [7:0] IO_PAGE     = IO_PAGE_DEF,
    parameter int         IO_TIMEOUT  = IO_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_responder_if.slave   bus,
    output logic [ADR_TOP:0] ram_addr,
    output logic [7:0]       ram_wdata,
    output logic             ram_en,
    output logic             ram_we,
    input  logic [7:0]       ram_rdata,
    output logic [7:0]       io_addr,
    output logic [7:0]       io_wdata,
    output logic             io_rd,
    output logic             io_wr,
    input  logic [7:0]       io_rdata,
    input  logic             io_ack,
    output logic             bus_err,
    input  logic             err_clr
);

    localparam logic [7:0] WAIT_LD =
        (WAIT_CYCLES > 0) ? 8'(WAIT_CYCLES - 1) : 8'd0;
    localparam logic [7:0] TMO_LD = 8'(IO_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [ADR_TOP:0] addr_q;
    logic [7:0]       data_q;
    logic             wr_q;
    logic             io_sel_q;
    logic [7:0]       io_q;

    logic             io_hit;
    logic             accept;
    logic             ack_take;
    logic             tmo;
    logic             tmr_load;
    logic [7:0]       tmr_ld_val;
    logic             tmr_dec;
    logic             tmr_zero;

    assign io_hit = (bus.m_addr[ADR_TOP -: 8] == IO_PAGE);

    bus_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_ld_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        ack_take   = 1'b0;
        tmo        = 1'b0;
        tmr_load   = 1'b0;
        tmr_ld_val = WAIT_LD;
        tmr_dec    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.m_req) begin
                    accept   = 1'b1;
                    tmr_load = 1'b1;
                    if (io_hit) begin
                        tmr_ld_val = TMO_LD;
                        state_d    = ST_IO_REQ;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                if (tmr_zero) state_d = ST_ACCESS;
                else          tmr_dec = 1'b1;
            end
            ST_ACCESS: state_d = ST_DONE;
            // Ack is checked first so a late ack still beats the timeout.
            ST_IO_REQ: begin
                if (io_ack) begin
                    ack_take = 1'b1;
                    state_d  = ST_DONE;
                end else if (tmr_zero) begin
                    tmo     = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            data_q   <= 8'd0;
            wr_q     <= 1'b0;
            io_sel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= bus.m_addr;
                data_q   <= bus.m_outdata;
                wr_q     <= bus.m_wr;
                io_sel_q <= io_hit;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_q    <= 8'd0;
            bus_err <= 1'b0;
        end else begin
            if (ack_take)  io_q <= io_rdata;
            else if (tmo)  io_q <= 8'hFF;
            // A timeout outranks a clear in the same cycle.
            if (tmo)          bus_err <= 1'b1;
            else if (err_clr) bus_err <= 1'b0;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = data_q;
    assign ram_en    = (state_q == ST_ACCESS);
    assign ram_we    = (state_q == ST_ACCESS) && wr_q;
    assign io_addr   = addr_q[7:0];
    assign io_wdata  = data_q;
    assign io_rd     = (state_q == ST_IO_REQ) && !wr_q;
    assign io_wr     = (state_q == ST_IO_REQ) && wr_q;

    assign bus.m_wait = rst_n && bus.m_req &&
                        (state_q != ST_DONE);
    assign bus.m_indata =
        (state_q == ST_DONE && !wr_q) ?
        (io_sel_q ? io_q : ram_rdata) : 8'h00;

endmodule
